// File: rtl/io_halt_handshake.sv
// io_halt_handshake: stalls the core on IN/OUT until the operator presses and releases confirm.
// Confirm is synchronized and debounced; IN data is captured at the debounced press.
module io_halt_handshake #(
  parameter int DATA_W   = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req,
  input  logic              out_req,
  input  logic [DATA_W-1:0] out_data,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              confirm_sw,
  output logic              halt_c,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic [DATA_W-1:0] display_data,
  output logic              busy
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {IDLE, ARM, WAIT_PRESS, WAIT_RELEASE} state_t;
  state_t r_state, w_next;
  logic r_c_s1, r_c_s2, r_db, r_is_in, r_in_valid;
  logic [DATA_W-1:0] r_d_s1, r_d_s2, r_in_data, r_disp;
  logic [CW-1:0] r_cnt;
  logic w_accept;
  assign w_accept = (r_state == IDLE) && (in_req || out_req);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_s1 <= 1'b0;
      r_c_s2 <= 1'b0;
      r_d_s1 <= '0;
      r_d_s2 <= '0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_c_s1 <= confirm_sw;
      r_c_s2 <= r_c_s1;
      r_d_s1 <= sw_data;
      r_d_s2 <= r_d_s1;
      // level flips only after DEBOUNCE consecutive disagreeing cycles
      if (r_c_s2 == r_db) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE - 1)) begin
        r_db  <= r_c_s2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE       ? (w_accept ? ARM : IDLE) :
             r_state == ARM        ? (r_db ? ARM : WAIT_PRESS) :
             r_state == WAIT_PRESS ? (r_db ? WAIT_RELEASE : WAIT_PRESS) :
                                     (r_db ? WAIT_RELEASE : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_in    <= 1'b0;
      r_disp     <= '0;
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
    end else begin
      if (w_accept) r_is_in <= in_req;
      if (w_accept && !in_req) r_disp <= out_data;
      if (r_state == WAIT_PRESS && r_db && r_is_in) r_in_data <= r_d_s2;
      r_in_valid <= (r_state == WAIT_RELEASE) && !r_db && r_is_in;
    end
  end
  assign halt_c       = r_state != IDLE;
  assign busy         = r_state != IDLE;
  assign in_data      = r_in_data;
  assign in_valid     = r_in_valid;
  assign display_data = r_disp;
endmodule

// File: tb/tb_io_halt_handshake.sv
// tb_io_halt_handshake: scenario tasks plus an in_valid scoreboard for io_halt_handshake.
module tb_io_halt_handshake;
  logic clk = 1'b0, rst_n = 1'b0, in_req = 1'b0, out_req = 1'b0, confirm_sw = 1'b1;
  logic [15:0] out_data = '0, sw_data = '0;
  logic halt_c, in_valid, busy, prev_iv = 1'b0;
  logic [15:0] in_data, display_data;
  logic [15:0] exp_q[$];
  logic [15:0] exp_d;
  int n_cmp = 0, n_err = 0, n_valid = 0;

  io_halt_handshake #(.DATA_W(16), .DEBOUNCE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .out_req(out_req), .out_data(out_data),
    .sw_data(sw_data), .confirm_sw(confirm_sw), .halt_c(halt_c), .in_data(in_data),
    .in_valid(in_valid), .display_data(display_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (halt_c !== busy) begin
        n_err++;
        $display("FAIL halt_eq_busy: halt_c=%b busy=%b", halt_c, busy);
      end
      n_cmp++;
      if (in_valid && prev_iv) begin
        n_err++;
        $display("FAIL in_valid_pulse: in_valid high %0d cycles in a row, required 1", 2);
      end
      if (in_valid === 1'b1) begin
        n_valid++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: in_data=%h with no transaction expected", in_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (in_data !== exp_d) begin
            n_err++;
            $display("FAIL in_data: got %h required %h", in_data, exp_d);
          end
        end
      end
    end
    prev_iv = in_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic i, input logic o, input logic [15:0] d);
    in_req = i; out_req = o; out_data = d;
    step(1);
    in_req = 0; out_req = 0;
  endtask

  task automatic hold(input logic v, input int n);
    confirm_sw = v;
    step(n);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic finish_txn(input logic exp_iv);
    int k = 0;
    confirm_sw = 0;
    while (k < 30) begin
      @(negedge clk);
      if (!halt_c) break;
      k++;
    end
    chk("halt_fall_timeout", 16'(k < 30), 16'd1);
    chk("valid_at_fall", 16'(in_valid), 16'(exp_iv));
    step(1);
  endtask

  task automatic test_reset_and_in;
    #12;
    chk("rst_halt", 16'(halt_c), 0);
    chk("rst_busy", 16'(busy), 0);
    chk("rst_valid", 16'(in_valid), 0);
    chk("rst_in_data", in_data, 0);
    chk("rst_display", display_data, 0);
    @(posedge clk); #1; rst_n = 1;
    hold(1, 10);
    pulse(1, 0, 0);
    @(negedge clk);
    chk("in_halt_rise", 16'(halt_c), 1);
    step(0);
    hold(1, 8);
    chk("arm_hold", 16'(halt_c), 1);
    hold(0, 6);
    chk("arm_release", 16'(halt_c), 1);
    sw_data = 16'hA5C3; exp_q.push_back(16'hA5C3);
    hold(1, 10);
    chk("press_halt", 16'(halt_c), 1);
    chk("press_capture", in_data, 16'hA5C3);
    finish_txn(1);
  endtask

  task automatic test_bounce;
    int v0 = n_valid;
    pulse(1, 0, 0);
    hold(0, 8);
    sw_data = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      hold(1, 3);
      hold(0, 3);
    end
    chk("bounce_halt", 16'(halt_c), 1);
    chk("bounce_nocap", in_data, 16'hA5C3);
    chk("bounce_novalid", 16'(n_valid - v0), 0);
    sw_data = 16'h1111; exp_q.push_back(16'h1111);
    hold(1, 10);
    finish_txn(1);
  endtask

  task automatic test_out;
    int v0 = n_valid;
    pulse(0, 1, 16'h1234);
    @(negedge clk);
    chk("out_halt", 16'(halt_c), 1);
    chk("out_display", display_data, 16'h1234);
    step(0);
    hold(0, 8);
    sw_data = 16'h9999;
    hold(1, 10);
    finish_txn(0);
    step(3);
    chk("out_novalid", 16'(n_valid - v0), 0);
    chk("out_display_hold", display_data, 16'h1234);
    chk("out_in_data_hold", in_data, 16'h1111);
  endtask

  task automatic test_collision;
    int v0 = n_valid;
    sw_data = 16'h5A5A;
    pulse(1, 1, 16'hFFFF);
    pulse(1, 0, 0);
    chk("coll_halt", 16'(halt_c), 1);
    chk("coll_display", display_data, 16'h1234);
    exp_q.push_back(16'h5A5A);
    hold(0, 8);
    hold(1, 10);
    finish_txn(1);
    step(4);
    chk("coll_idle", 16'(halt_c), 0);
    chk("coll_one_valid", 16'(n_valid - v0), 1);
  endtask

  task automatic test_reset_midop;
    int v0 = n_valid;
    pulse(1, 0, 0);
    hold(0, 8);
    sw_data = 16'h7777;
    hold(1, 10);
    rst_n = 0; confirm_sw = 0;
    #1;
    chk("mid_rst_halt", 16'(halt_c), 0);
    chk("mid_rst_busy", 16'(busy), 0);
    chk("mid_rst_in_data", in_data, 0);
    step(3);
    rst_n = 1;
    step(8);
    chk("mid_rst_novalid", 16'(n_valid - v0), 0);
    chk("mid_rst_idle", 16'(halt_c), 0);
    pulse(1, 0, 0);
    chk("mid_rst_reaccept", 16'(halt_c), 1);
    sw_data = 16'h3C3C; exp_q.push_back(16'h3C3C);
    hold(0, 4);
    hold(1, 10);
    finish_txn(1);
  endtask

  task automatic test_data_change;
    pulse(1, 0, 0);
    hold(0, 8);
    sw_data = 16'h0F0F; exp_q.push_back(16'h0F0F);
    hold(1, 10);
    sw_data = 16'hF0F0;
    hold(1, 3);
    finish_txn(1);
    step(3);
    chk("change_in_data", in_data, 16'h0F0F);
    chk("queue_drained", 16'(exp_q.size()), 0);
  endtask

  initial begin
    test_reset_and_in();
    test_bounce();
    test_out();
    test_collision();
    test_reset_midop();
    test_data_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/io_halt_handshake.md
Name: io_halt_handshake

Overview:
- Processor-side requester for the operator halt/resume protocol.
- The control unit pulses a request when it executes an IN or OUT instruction. This block then holds halt_c high, stalling the datapath until the operator completes a full press-and-release of the confirm switch.
- For IN, the switch data bus is captured and returned to the datapath. For OUT, the value to display is latched.
- Sits between the control unit, the board switches/LED display and the core's halt input.

Parameters:
- DATA_W, 16, width of switch data bus, in_data, out_data and display_data.
- DEBOUNCE, 4, consecutive stable synchronized cycles required before the debounced confirm level changes (legal range ≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_req  input  1  one-cycle pulse from control unit: IN instruction, read operator data.
- out_req  input  1  one-cycle pulse from control unit: OUT instruction, show out_data and wait.
- out_data  input  DATA_W  value to display; sampled only in the cycle out_req is accepted.
- sw_data  input  DATA_W  board data switches; asynchronous.
- confirm_sw  input  1  board confirm switch; asynchronous, bouncy.
- halt_c  output  1  halt request to the core; 1 stalls the datapath.
- in_data  output  DATA_W  captured operator value; holds until the next IN capture.
- in_valid  output  1  one-cycle pulse: in_data valid, IN transaction complete.
- display_data  output  DATA_W  LED display value; holds until the next accepted OUT.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - halt_c=0, in_valid=0, in_data=0, display_data=0, busy=0.
  - Synchronizers, debounced level and debounce counter cleared to 0.
  - Reset mid-transaction aborts it: halt_c drops immediately and no in_valid is produced.
- Synchronization:
  - confirm_sw passes through a 2-flop synchronizer giving sync_c.
  - sw_data passes through a 2-flop per-bit synchronizer giving sync_d.
- Debounce:
  - The counter increments while sync_c != sw_db and clears when they are equal.
  - When the counter reaches DEBOUNCE, sw_db takes sync_c and the counter clears.
  - A pulse shorter than DEBOUNCE cycles never changes sw_db.
- Request acceptance (IDLE only):
  - in_req has priority over out_req when both are high in the same cycle; the out_req is dropped.
  - Requests arriving while busy=1 are ignored. No queueing.
  - Accepting any request: next cycle state=ARM, halt_c=1, busy=1, and the request type (IN/OUT) is stored.
  - Accepting out_req: display_data<=out_data on the same edge.
- States:
  - IDLE: halt_c=0. Transitions on an accepted request as above.
  - ARM: waits for sw_db==0, so a switch already held high at request time does not count as a confirm. Goes to WAIT_PRESS in the cycle after sw_db==0 is seen, or directly if sw_db is already 0.
  - WAIT_PRESS: waits for sw_db==1. On that edge, if type=IN, in_data<=sync_d; then goes to WAIT_RELEASE. Data is captured at the debounced press, not at release.
  - WAIT_RELEASE: waits for sw_db==0. Then goes to IDLE, and on that same clock edge halt_c<=0, busy<=0, and in_valid<=1 for one cycle if type=IN. OUT transactions never pulse in_valid.
- Net behaviour:
  - halt_c rises exactly one cycle after an accepted request.
  - halt_c falls exactly one cycle after sw_db falls in WAIT_RELEASE.
  - A new request is accepted in the cycle after the return to IDLE.
- Invariants:
  - halt_c == busy at all times.
  - in_valid is never high in two consecutive cycles.

Test Plan:
- Reset, then IN: rst_n low with confirm_sw=1, release reset, pulse in_req → halt_c=1 next cycle and stays 1 while confirm_sw=1. Drive 0 (stable 6 cycles) → ARM→WAIT_PRESS. Set sw_data=16'hA5C3, drive confirm 1 stable, then 0 stable → in_data=A5C3 latched at press. in_valid high exactly one cycle, coinciding with halt_c falling.
- Bounce rejection (DEBOUNCE=4): in WAIT_PRESS, drive confirm_sw high for 3 cycles then low, repeated 5 times → sw_db stays 0, halt_c stays 1, no capture.
- OUT: pulse out_req with out_data=16'h1234 → display_data=1234 at halt_c rise; full press/release drops halt_c with in_valid never asserted; display_data remains 1234 afterwards.
- Collisions: in_req and out_req in the same cycle with out_data=16'hFFFF → IN transaction only, display_data unchanged. A second in_req while busy → ignored; exactly one in_valid results.
- Reset mid-op: assert rst_n=0 in WAIT_RELEASE → halt_c=0 immediately (asynchronous), no in_valid, in_data=0. After release, a new in_req is accepted normally.
- Data changing after press: change sw_data from 16'h0F0F to 16'hF0F0 between the debounced press and release → in_data=0F0F.
